// File: rtl/logic_gate_pkg.sv
// Shared definitions for the bitwise gate pipeline: gate-select encoding and
// the layout of a buffered result entry.
package logic_gate_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned FLAG_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOTA = 3'd6,
        OP_PASS = 3'd7
    } gate_op_e;

endpackage

// File: rtl/logic_gate_pipe_result_fifo2.sv
// Two-entry in-order synchronous FIFO with valid/ready on both sides.
// Entry 0 is always the head; outputs are registered and read zero when empty.
module result_fifo2 #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic [1:0]    count_q, count_d;
    logic [DW-1:0] slot0_q, slot0_d;
    logic [DW-1:0] slot1_q, slot1_d;
    logic          push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = out_valid ? slot0_q : '0;

    always_comb begin
        count_d = count_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        push    = in_valid && (count_q != 2'd2);
        pop     = out_ready && (count_q != 2'd0);
        // Push and pop together can only happen with one entry held.
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) slot0_d = in_data;
                else                 slot1_d = in_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: slot0_d = in_data;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            count_q <= count_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Bitwise gate evaluator with zero/ones flags, buffered through a 2-entry
// result FIFO, plus a wrapping count of completed output handshakes.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic [CNT_W-1:0] txn_count
);

    localparam int unsigned DW = WIDTH + FLAG_W;

    gate_op_e         op;
    logic [WIDTH-1:0] y;
    logic             y_zero, y_ones;
    logic [DW-1:0]    fifo_out;
    logic [CNT_W-1:0] txn_count_q, txn_count_d;

    assign op = gate_op_e'(in_op);

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND:  y = in_a & in_b;
            OP_OR:   y = in_a | in_b;
            OP_XOR:  y = in_a ^ in_b;
            OP_NAND: y = ~(in_a & in_b);
            OP_NOR:  y = ~(in_a | in_b);
            OP_XNOR: y = ~(in_a ^ in_b);
            OP_NOTA: y = ~in_a;
            OP_PASS: y = in_a;
            default: y = '0;
        endcase
        y_zero = (y == '0);
        y_ones = (y == '1);
    end

    result_fifo2 #(.DW(DW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({y_zero, y_ones, y}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fifo_out)
    );

    // Empty FIFO reads all-zero, so both flags drop with out_valid.
    assign out_zero = fifo_out[DW-1];
    assign out_ones = fifo_out[DW-2];
    assign out_y    = fifo_out[WIDTH-1:0];

    always_comb begin
        txn_count_d = txn_count_q;
        if (out_valid && out_ready) txn_count_d = txn_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) txn_count_q <= '0;
        else     txn_count_q <= txn_count_d;
    end

    assign txn_count = txn_count_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed-vector bench for logic_gate_pipe (WIDTH=8, CNT_W=4).
module tb_logic_gate_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [2:0] in_op = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_y;
    logic       out_zero;
    logic       out_ones;
    logic [3:0] txn_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_ones  (out_ones),
        .txn_count (txn_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_y !== 8'h00) begin failures++; $display("FAIL reset_out_y got=%h exp=00", out_y); end
        checks++; if (txn_count !== 4'd0) begin failures++; $display("FAIL reset_txn got=%0d exp=0", txn_count); end
        checks++; if ({out_zero, out_ones} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {out_zero, out_ones}); end
    endtask

    task automatic test_all_ops();
        logic [7:0] exp_y [8];
        exp_y = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h3A, 8'hC5};
        out_ready = 1'b1;
        for (int op = 0; op < 8; op++) begin
            drive(1'b1, 3'(op), 8'hC5, 8'h3A);
            tick();
            checks++; if (out_valid !== 1'b1 || out_y !== exp_y[op])
                begin failures++; $display("FAIL op%0d_out_y got=%b/%h exp=1/%h", op, out_valid, out_y, exp_y[op]); end
            checks++; if ({out_zero, out_ones} !== {exp_y[op] == 8'h00, exp_y[op] == 8'hFF})
                begin failures++; $display("FAIL op%0d_flags got=%b exp=%b", op, {out_zero, out_ones}, {exp_y[op] == 8'h00, exp_y[op] == 8'hFF}); end
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        tick();
        checks++; if (out_valid !== 1'b0 || out_y !== 8'h00 || {out_zero, out_ones} !== 2'b00)
            begin failures++; $display("FAIL ops_empty got=%b/%h/%b exp=0/00/00", out_valid, out_y, {out_zero, out_ones}); end
        checks++; if (txn_count !== 4'd8) begin failures++; $display("FAIL ops_txn got=%0d exp=8", txn_count); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 8'hF0, 8'h3C);
        tick();
        checks++; if (in_ready !== 1'b1 || out_y !== 8'h30) begin failures++; $display("FAIL bp_first got=%b/%h exp=1/30", in_ready, out_y); end
        drive(1'b1, 3'd0, 8'h0F, 8'hFF);
        tick();
        checks++; if (in_ready !== 1'b0 || out_y !== 8'h30) begin failures++; $display("FAIL bp_full got=%b/%h exp=0/30", in_ready, out_y); end
        drive(1'b1, 3'd0, 8'hAA, 8'hFF);
        tick();
        checks++; if (in_ready !== 1'b0 || out_y !== 8'h30) begin failures++; $display("FAIL bp_hold got=%b/%h exp=0/30", in_ready, out_y); end
        out_ready = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1 || out_y !== 8'h0F) begin failures++; $display("FAIL bp_drain1 got=%b/%h exp=1/0f", in_ready, out_y); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_y !== 8'hAA) begin failures++; $display("FAIL bp_third got=%b/%h exp=1/aa", out_valid, out_y); end
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
        checks++; if (txn_count !== 4'd11) begin failures++; $display("FAIL bp_txn got=%0d exp=11", txn_count); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 8'h01, 8'h02);
        tick();
        drive(1'b1, 3'd2, 8'hFF, 8'h0F);
        tick();
        checks++; if (in_ready !== 1'b0 || out_y !== 8'h03) begin failures++; $display("FAIL b2b_full got=%b/%h exp=0/03", in_ready, out_y); end
        drive(1'b1, 3'd7, 8'h55, 8'h00);
        out_ready = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1 || out_y !== 8'hF0) begin failures++; $display("FAIL b2b_pop_full got=%b/%h exp=1/f0", in_ready, out_y); end
        tick();
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_y !== 8'h55)
            begin failures++; $display("FAIL b2b_pushpop got=%b/%b/%h exp=1/1/55", out_valid, in_ready, out_y); end
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_occ1 got=%b exp=0", out_valid); end
        checks++; if (txn_count !== 4'd14) begin failures++; $display("FAIL b2b_txn got=%0d exp=14", txn_count); end
    endtask

    task automatic test_counter_wrap();
        rst = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 3'd7, 8'(i), 8'h00);
            tick();
        end
        checks++; if (txn_count !== 4'd0) begin failures++; $display("FAIL wrap_16 got=%0d exp=0", txn_count); end
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        tick();
        checks++; if (txn_count !== 4'd1) begin failures++; $display("FAIL wrap_17 got=%0d exp=1", txn_count); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        drive(1'b1, 3'd7, 8'h12, 8'h00);
        tick();
        drive(1'b1, 3'd7, 8'h34, 8'h00);
        tick();
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL mrst_full got=%b/%b exp=1/0", out_valid, in_ready); end
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 3'd7, 8'h77, 8'h00);
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_y !== 8'h00)
            begin failures++; $display("FAIL mrst_state got=%b/%b/%h exp=0/1/00", out_valid, in_ready, out_y); end
        checks++; if (txn_count !== 4'd0) begin failures++; $display("FAIL mrst_txn got=%0d exp=0", txn_count); end
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_stale%0d got=%b/%h exp=0", i, out_valid, out_y); end
        end
        out_ready = 1'b0;
        drive(1'b1, 3'd7, 8'h77, 8'h00);
        tick();
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        checks++; if (out_valid !== 1'b1 || out_y !== 8'h77) begin failures++; $display("FAIL mrst_fresh got=%b/%h exp=1/77", out_valid, out_y); end
    endtask

    initial begin
        test_reset();
        test_all_ops();
        test_backpressure();
        test_back_to_back();
        test_counter_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of the completed-transaction counter.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid  input  1  operand set present.
REQ-006 The block SHALL have port in_ready  output  1  block can accept an operand set.
REQ-007 The block SHALL have port in_a  input  WIDTH  operand A.
REQ-008 The block SHALL have port in_b  input  WIDTH  operand B.
REQ-009 The block SHALL have port in_op  input  3  gate select.
REQ-010 The block SHALL have port out_valid  output  1  result present.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 The block SHALL have port out_y  output  WIDTH  bitwise result.
REQ-013 The block SHALL have port out_zero  output  1  out_y is all zeros.
REQ-014 The block SHALL have port out_ones  output  1  out_y is all ones.
REQ-015 The block SHALL have port txn_count  output  CNT_W  count of completed output handshakes.

Function
REQ-016 in_op encoding SHALL be: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A (in_b ignored), 7 PASS A.
REQ-017 An input transfer SHALL occur on a rising clk edge where in_valid=1 and in_ready=1; in_a, in_b and in_op SHALL be sampled only on that edge.
REQ-018 On each input transfer, the result and its flags SHALL be computed from the sampled operands and written into a 2-entry in-order result buffer.
REQ-019 out_valid SHALL be 1 exactly when the buffer holds at least 1 entry; out_y, out_zero and out_ones SHALL present the oldest entry.
REQ-020 Latency SHALL be 1 cycle: a result accepted at edge N SHALL be visible with out_valid=1 after edge N; there SHALL be no combinational input-to-output path.
REQ-021 in_ready SHALL be 1 exactly when the buffer holds fewer than 2 entries; it SHALL NOT depend combinationally on out_ready.
REQ-022 An output transfer SHALL occur on an edge where out_valid=1 and out_ready=1, and the head entry SHALL be removed on that edge.
REQ-023 When an input transfer and an output transfer occur on the same edge, occupancy SHALL be unchanged and ordering SHALL be preserved.
REQ-024 When the buffer is full, in_valid SHALL be ignored, even if out_ready=1 on that cycle.
REQ-025 When the buffer is empty, out_y SHALL be 0, out_zero SHALL be 0 and out_ones SHALL be 0.
REQ-026 Once out_valid=1, out_y, out_zero and out_ones SHALL remain stable until the output transfer occurs.
REQ-027 txn_count SHALL increment by 1 on every output transfer and SHALL wrap from 2^CNT_W-1 to 0.
REQ-028 out_zero and out_ones SHALL both be 1 for no legal WIDTH; for WIDTH=1 they SHALL be mutually exclusive whenever out_valid=1.

Reset
REQ-029 While rst=1 at a clk edge, the block SHALL empty the buffer and clear txn_count to 0, so that in_ready=1, out_valid=0, out_y=0, out_zero=0 and out_ones=0 after that edge.
REQ-030 A reset asserted mid-operation SHALL discard all buffered results; the block SHALL NOT complete any transfer on a reset edge.

Structure
REQ-031 The op encoding, as a 3-bit enumerated type with named constants, SHALL reside in a shared package logic_gate_pkg.
REQ-032 Buffering SHALL be implemented in one sub-module, result_fifo2, a parametrised-width 2-entry synchronous FIFO with valid/ready on both sides.
REQ-033 The gate evaluation and flag generation SHALL be combinational logic in logic_gate_pipe, ahead of result_fifo2.

Verification
REQ-034 Reset: hold rst=1 for 2 cycles -> in_ready=1, out_valid=0, out_y=0, txn_count=0.
REQ-035 All ops: WIDTH=8, a=8'hC5, b=8'h3A, ops 0..7 with out_ready=1 -> out_y = 00, FF, FF, FF, 00, 00, 3A, C5, each 1 cycle after its accept, with out_ones/out_zero matching.
REQ-036 Backpressure: out_ready=0, issue 3 AND ops -> only 2 accepted, in_ready=0 after the second; raise out_ready -> results drain in order, and the third op is accepted once in_ready returns to 1.
REQ-037 Simultaneous transfers: full buffer, in_valid=1, out_ready=1 -> head pops and in_ready rises next cycle; with 1 entry held, push and pop on the same edge -> occupancy stays 1.
REQ-038 Counter wrap: CNT_W=4, 17 output transfers -> txn_count=1.
REQ-039 Mid-operation reset: buffer holding 2 entries, rst=1 for 1 cycle -> out_valid=0, txn_count=0, and the pre-reset results never appear on the output.
